hazard_stall_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It detects load-use hazards between the D and E stages and tracks the multi-cycle multiply/divide unit. It drives the hold signals for the PC and the D-stage register, and the bubble (stop) input of the E-stage register. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/cpu_defs.sv | 9 +
 rtl/md_busy_timer.sv | 39 +++
 rtl/hazard_stall_ctrl.sv | 88 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the 5-stage MIPS core.
// Contents: register-index width and the default busy latencies of the
// multiply/divide unit. Latencies count cycles after the start cycle.
package cpu_defs;
  localparam int REG_W        = 5;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;
endpackage

// File: rtl/md_busy_timer.sv
// Busy timer for the multi-cycle multiply/divide unit.
// Ports:
//   clk        - system clock, rising edge
//   i_reset    - asynchronous active-low reset, clears the timer
//   i_start    - an E-stage instruction starts mult/div this cycle
//   i_is_div   - qualifies i_start: 1 = divide, 0 = multiply
//   o_busy     - unit busy (down-counter non-zero)
// The counter width must hold max(MULT_LAT, DIV_LAT).
module md_busy_timer
  import cpu_defs::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // A start always reloads, even while busy: a flush can abandon an
  // operation and a new one then restarts the full latency.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use hazards between D and E, tracks the mult/div unit and
// drives the PC/D holds and the E-stage bubble. Keeps a saturating count
// of stalled cycles for performance debug.
// Ports:
//   clk                 - system clock, rising edge
//   i_reset             - asynchronous active-low reset
//   i_d_rs, i_d_rt      - source register fields of the D instruction
//   i_d_use_rs/_rt      - D instruction actually reads rs / rt
//   i_d_is_md           - D instruction touches the mult/div unit or HI/LO
//   i_e_mem_read        - E instruction is a load
//   i_e_wa              - destination register of the E instruction
//   i_e_md_start        - E instruction starts mult/div this cycle
//   i_e_md_is_div       - qualifies i_e_md_start: 1 = divide
//   o_stall_f/o_stall_d - hold PC / D-stage register
//   o_flush_e           - bubble into the E-stage register
//   o_md_busy           - mult/div unit busy
//   o_stall_cnt         - saturating stalled-cycle count
module hazard_stall_ctrl
  import cpu_defs::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [REG_W-1:0] i_d_rs,
  input  logic [REG_W-1:0] i_d_rt,
  input  logic             i_d_use_rs,
  input  logic             i_d_use_rt,
  input  logic             i_d_is_md,
  input  logic             i_e_mem_read,
  input  logic [REG_W-1:0] i_e_wa,
  input  logic             i_e_md_start,
  input  logic             i_e_md_is_div,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_flush_e,
  output logic             o_md_busy,
  output logic [31:0]      o_stall_cnt
);

  logic        w_md_busy;
  logic        w_lu;
  logic        w_md;
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_start  (i_e_md_start),
    .i_is_div (i_e_md_is_div),
    .o_busy   (w_md_busy)
  );

  // $0 is hard-wired zero, so a load "to $0" never produces a value to wait for.
  assign w_lu = i_e_mem_read && (i_e_wa != '0) &&
                ((i_d_use_rs && (i_d_rs == i_e_wa)) ||
                 (i_d_use_rt && (i_d_rt == i_e_wa)));

  // The start cycle itself already blocks a following mult/div-class instruction.
  assign w_md = i_d_is_md && (w_md_busy || i_e_md_start);

  // Gated with reset so all outputs drop as soon as reset asserts,
  // regardless of what the pipeline presents on the inputs.
  assign w_stall = (w_lu || w_md) && i_reset;

  assign o_stall_f   = w_stall;
  assign o_stall_d   = w_stall;
  assign o_flush_e   = w_stall;
  assign o_md_busy   = w_md_busy;
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        i_reset;
  logic [4:0]  i_d_rs, i_d_rt, i_e_wa;
  logic        i_d_use_rs, i_d_use_rt, i_d_is_md;
  logic        i_e_mem_read, i_e_md_start, i_e_md_is_div;
  logic        o_stall_f, o_stall_d, o_flush_e, o_md_busy;
  logic [31:0] o_stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  hazard_stall_ctrl dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_d_rs        (i_d_rs),
    .i_d_rt        (i_d_rt),
    .i_d_use_rs    (i_d_use_rs),
    .i_d_use_rt    (i_d_use_rt),
    .i_d_is_md     (i_d_is_md),
    .i_e_mem_read  (i_e_mem_read),
    .i_e_wa        (i_e_wa),
    .i_e_md_start  (i_e_md_start),
    .i_e_md_is_div (i_e_md_is_div),
    .o_stall_f     (o_stall_f),
    .o_stall_d     (o_stall_d),
    .o_flush_e     (o_flush_e),
    .o_md_busy     (o_md_busy),
    .o_stall_cnt   (o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       is_md;
    logic       mem_read;
    logic [4:0] wa;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk(name, {29'd0, o_stall_f, o_stall_d, o_flush_e}, {29'd0, exp, exp, exp});
  endtask

  task automatic idle();
    i_d_rs = 5'd0; i_d_rt = 5'd0; i_e_wa = 5'd0;
    i_d_use_rs = 1'b0; i_d_use_rt = 1'b0; i_d_is_md = 1'b0;
    i_e_mem_read = 1'b0; i_e_md_start = 1'b0; i_e_md_is_div = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    exp_cnt = 32'd0;
  endtask

  // Let any mult/div operation drain so sequences start from an idle unit.
  task automatic drain();
    int n = 0;
    idle();
    while (o_md_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain_idle", {31'd0, o_md_busy}, 32'd0);
  endtask

  initial begin
    int busy_n;
    logic [31:0] sat_exp;

    vecs[0] = '{rs:5'd0, rt:5'd8,  use_rs:1'b0, use_rt:1'b1, is_md:1'b0, mem_read:1'b1, wa:5'd8,  exp_stall:1'b1};
    vecs[1] = '{rs:5'd0, rt:5'd0,  use_rs:1'b1, use_rt:1'b1, is_md:1'b0, mem_read:1'b1, wa:5'd0,  exp_stall:1'b0};
    vecs[2] = '{rs:5'd0, rt:5'd8,  use_rs:1'b0, use_rt:1'b0, is_md:1'b0, mem_read:1'b1, wa:5'd8,  exp_stall:1'b0};
    vecs[3] = '{rs:5'd3, rt:5'd9,  use_rs:1'b1, use_rt:1'b1, is_md:1'b0, mem_read:1'b1, wa:5'd3,  exp_stall:1'b1};
    vecs[4] = '{rs:5'd3, rt:5'd9,  use_rs:1'b0, use_rt:1'b1, is_md:1'b0, mem_read:1'b1, wa:5'd3,  exp_stall:1'b0};
    vecs[5] = '{rs:5'd7, rt:5'd7,  use_rs:1'b1, use_rt:1'b1, is_md:1'b0, mem_read:1'b0, wa:5'd7,  exp_stall:1'b0};
    vecs[6] = '{rs:5'd1, rt:5'd2,  use_rs:1'b1, use_rt:1'b1, is_md:1'b1, mem_read:1'b1, wa:5'd4,  exp_stall:1'b0};
    vecs[7] = '{rs:5'd31, rt:5'd31, use_rs:1'b1, use_rt:1'b1, is_md:1'b0, mem_read:1'b1, wa:5'd31, exp_stall:1'b1};

    // Reset state, with a load-use pattern on the inputs during reset.
    idle();
    i_reset = 1'b0;
    i_e_mem_read = 1'b1; i_e_wa = 5'd8; i_d_use_rt = 1'b1; i_d_rt = 5'd8;
    @(negedge clk);
    #1;
    chk_stall("reset_stall", 1'b0);
    chk("reset_md_busy", {31'd0, o_md_busy}, 32'd0);
    chk("reset_stall_cnt", o_stall_cnt, 32'd0);
    idle();
    @(negedge clk);
    i_reset = 1'b1;
    exp_cnt = 32'd0;

    // Table-driven combinational hazard vectors, unit idle.
    for (int i = 0; i < 8; i++) begin
      i_d_rs = vecs[i].rs; i_d_rt = vecs[i].rt;
      i_d_use_rs = vecs[i].use_rs; i_d_use_rt = vecs[i].use_rt;
      i_d_is_md = vecs[i].is_md; i_e_mem_read = vecs[i].mem_read;
      i_e_wa = vecs[i].wa;
      #1;
      chk_stall($sformatf("vec%0d_stall", i), vecs[i].exp_stall);
      @(posedge clk);
      if (vecs[i].exp_stall) exp_cnt = exp_cnt + 1;
      @(negedge clk);
    end
    idle();
    #1;
    chk("vec_stall_cnt", o_stall_cnt, exp_cnt);

    // Multiply with a dependent md instruction held in D: 6 stall cycles.
    do_reset();
    i_e_md_start = 1'b1; i_e_md_is_div = 1'b0; i_d_is_md = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) i_e_md_start = 1'b0;
      #1;
      chk_stall($sformatf("mult_c%0d_stall", c), (c <= 6));
      chk($sformatf("mult_c%0d_busy", c), {31'd0, o_md_busy}, {31'd0, (c >= 2 && c <= 6)});
      @(posedge clk);
      if (c <= 6) exp_cnt = exp_cnt + 1;
      @(negedge clk);
    end
    #1;
    chk("mult_stall_cnt", o_stall_cnt, 32'd6);
    idle();

    // Divide with an unrelated D instruction: no stall, busy 10 cycles.
    do_reset();
    i_e_md_start = 1'b1; i_e_md_is_div = 1'b1; i_d_is_md = 1'b0;
    busy_n = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) i_e_md_start = 1'b0;
      #1;
      if (o_stall_f || o_flush_e) chk_stall($sformatf("div_c%0d_stall", c), 1'b0);
      if (o_md_busy) busy_n++;
      @(negedge clk);
    end
    chk("div_busy_cycles", busy_n, 32'd10);
    chk("div_stall_cnt", o_stall_cnt, 32'd0);

    // Load-use and md hazard together: one stall, counted once.
    do_reset();
    i_e_md_start = 1'b1; i_d_is_md = 1'b1;
    i_e_mem_read = 1'b1; i_e_wa = 5'd12; i_d_use_rs = 1'b1; i_d_rs = 5'd12;
    #1;
    chk_stall("both_stall", 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("both_stall_cnt", o_stall_cnt, 32'd1);
    drain();

    // Restart at cnt=3 reloads to MULT_LAT: 5 busy cycles follow the restart.
    do_reset();
    i_e_md_start = 1'b1; i_e_md_is_div = 1'b0;
    @(negedge clk);                   // cnt = 5
    i_e_md_start = 1'b0;
    @(negedge clk);                   // cnt = 4
    @(negedge clk);                   // cnt = 3
    i_e_md_start = 1'b1;
    @(negedge clk);                   // reloaded
    i_e_md_start = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!o_md_busy) break;
      busy_n++;
      @(negedge clk);
    end
    chk("restart_busy_cycles", busy_n, 32'd5);

    // Reset mid-divide with cnt=7 and a stalled md instruction in D.
    do_reset();
    i_e_md_start = 1'b1; i_e_md_is_div = 1'b1;
    @(negedge clk);                   // cnt = 10
    i_e_md_start = 1'b0;
    @(negedge clk);                   // 9
    @(negedge clk);                   // 8
    @(negedge clk);                   // 7
    i_d_is_md = 1'b1;
    #1;
    chk_stall("midop_stall_before", 1'b1);
    #1;
    i_reset = 1'b0;
    #1;
    chk("midop_md_busy", {31'd0, o_md_busy}, 32'd0);
    chk_stall("midop_stall", 1'b0);
    chk("midop_stall_cnt", o_stall_cnt, 32'd0);
    @(negedge clk);
    i_reset = 1'b1;
    idle();
    busy_n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (o_md_busy) busy_n++;
    end
    chk("post_reset_busy", busy_n, 32'd0);

    // Saturation of the stall counter.
    @(negedge clk);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    chk("sat_preload", o_stall_cnt, 32'hFFFF_FFFE);
    sat_exp = 32'hFFFF_FFFE;
    i_e_mem_read = 1'b1; i_e_wa = 5'd5; i_d_use_rt = 1'b1; i_d_rt = 5'd5;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      if (sat_exp != 32'hFFFF_FFFF) sat_exp = sat_exp + 1;
      chk($sformatf("sat_c%0d", c), o_stall_cnt, sat_exp);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
